shift_normalizer: RTL and testbench
===================================

// Module: shift_normalizer
// PURPOSE
//  Iterative normalizer: inverse companion of shifter_8bit. Given a word, it finds
//  the shift that brings the first set bit to the MSB (dir=0, left) or to the LSB
//  (dir=1, right). Outputs the normalized word and the shift amount. Feeding
//  data_out, shift_amt and the opposite dir into shifter_8bit restores data_in.
//  One bit per cycle; start/busy/done handshake; sits beside shifter_8bit in the datapath.
// PARAMETERS
//  WIDTH  8  data width; AMT_W = $clog2(WIDTH) is a localparam (3 at default)
// PORTS
//  Clock      in   1      single clock, rising edge
//  Reset_n    in   1      asynchronous, active-low reset
//  start      in   1      request; accepted only on an edge where busy==0
//  data_in    in   WIDTH  word to normalize; sampled on the accepting edge
//  dir        in   1      0=normalize toward MSB (left), 1=toward LSB (right); sampled with data_in
//  busy       out  1      high from the accepting edge until the edge that asserts done
//  done       out  1      single-cycle pulse: result valid
//  data_out   out  WIDTH  normalized word, held until the next done
//  shift_amt  out  AMT_W  number of 1-bit shifts applied, held until the next done
//  zero       out  1      data_in was all zeros, held until the next done
// BEHAVIOUR
//  - Reset (Reset_n=0, async): state=IDLE; busy, done, data_out, shift_amt and zero all 0.
//    A reset during SHIFT aborts the operation; no done pulse follows release.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE. busy=0 in IDLE and DONE.
//  - Accept (start=1 and busy=0, in IDLE or DONE): work_reg<=data_in, dir_reg<=dir,
//    cnt<=0, state<=SHIFT. Back-to-back accept from DONE is legal. Any start seen
//    while busy=1 is ignored: no queueing, no effect.
//  - SHIFT, each edge: the target bit is work_reg[WIDTH-1] (dir_reg=0) or work_reg[0] (dir_reg=1).
//    If work_reg==0, or the target bit=1, or cnt==WIDTH-1: state<=DONE, done<=1,
//    data_out<=work_reg, shift_amt<=cnt, zero<=(work_reg==0).
//    Otherwise, shift work_reg by 1 toward the target end (zero fill) and cnt<=cnt+1.
//  - DONE: done deasserts on the next edge. State goes to IDLE, or to SHIFT if start=1.
//  - Latency: done is asserted N+1 edges after the accepting edge, where N = final
//    shift_amt (0..WIDTH-1). Worst case is WIDTH edges.
//  - All-zero input: zero=1, shift_amt=0, data_out=0, done 1 edge after accept.
//  - cnt never exceeds WIDTH-1 and never wraps. Outputs change only on done edges or reset.
// TESTING
//  1. Reset_n=0 with random inputs -> busy=done=zero=0, data_out=0, shift_amt=0,
//     immediately (async, no clock edge needed).
//  2. data_in=8'b00101010, dir=0, start pulse -> done 3 edges after accept;
//     data_out=8'b10101000, shift_amt=2, zero=0; busy high for exactly those 3 cycles.
//  3. data_in=8'b11110000, dir=1 -> done 5 edges after accept; data_out=8'b00001111,
//     shift_amt=4. Also 8'b10101010, dir=0 -> shift_amt=0, done after 1 edge.
//  4. data_in=8'h00, either dir -> zero=1, data_out=8'h00, shift_amt=0, done after 1 edge.
//     data_in=8'h01, dir=0 -> data_out=8'h80, shift_amt=7, done after 8 edges.
//     During this, pulse start with data_in=8'hFF -> the pulse is ignored and the result is unchanged.
//  5. Back-to-back: hold start=1 with new data during the done cycle -> accepted,
//     busy re-asserts on that edge, second result correct. Round-trip: drive shifter_8bit
//     with data_out, shift_amt and ~dir -> its output equals the original data_in
//     (non-zero inputs, full sweep 8'h01..8'hFF).
//  6. Reset_n pulsed low 2 cycles after accept of 8'h01 -> busy=0 at once, no done after release;
//     a fresh start then completes normally.

Source files
------------

// File: rtl/shift_normalizer_if.sv
// Handshake and result bundle for the iterative shift normalizer.
interface shift_normalizer_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned AMT_W = $clog2(WIDTH);

    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             dir;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] data_out;
    logic [AMT_W-1:0] shift_amt;
    logic             zero;

    // Requester side: issues start with operands, observes status and result.
    modport master (
        output start, data_in, dir,
        input  busy, done, data_out, shift_amt, zero
    );

    // Normalizer side.
    modport slave (
        input  start, data_in, dir,
        output busy, done, data_out, shift_amt, zero
    );
endinterface

// File: rtl/shift_normalizer.sv
// Iterative normalizer: shifts a word one bit per cycle until its first set bit
// reaches the MSB (dir=0) or the LSB (dir=1), reporting the result and the
// number of shifts. Undoing the shift with the opposite direction restores the input.
module shift_normalizer #(
    parameter int unsigned WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    shift_normalizer_if.slave bus
);
    localparam int unsigned AMT_W = $clog2(WIDTH);
    localparam logic [AMT_W-1:0] CntMax = AMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] work_q;
    logic             dir_q;
    logic [AMT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] data_out_q;
    logic [AMT_W-1:0] shift_amt_q;
    logic             zero_q;

    logic             target_bit;
    logic             work_zero;
    logic             finish;

    // Decide whether the current working word is already normalized.
    always_comb begin
        target_bit = dir_q ? work_q[0] : work_q[WIDTH-1];
        work_zero  = (work_q == '0);
        finish     = work_zero || target_bit || (cnt_q == CntMax);
    end

    // Control FSM with registered status and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            work_q      <= '0;
            dir_q       <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            data_out_q  <= '0;
            shift_amt_q <= '0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        work_q  <= bus.data_in;
                        dir_q   <= bus.dir;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StShift;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StShift: begin
                    if (finish) begin
                        state_q     <= StDone;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        data_out_q  <= work_q;
                        shift_amt_q <= cnt_q;
                        zero_q      <= work_zero;
                    end else begin
                        work_q <= dir_q ? (work_q >> 1) : (work_q << 1);
                        cnt_q  <= cnt_q + AMT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Start requests while busy fall through the StShift arm untouched.
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.data_out  = data_out_q;
    assign bus.shift_amt = shift_amt_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_shift_normalizer.sv
// Directed bench for shift_normalizer: reset, hand-computed vectors, ignored
// start while busy, back-to-back accepts, round-trip sweep and mid-run reset.
module tb_shift_normalizer;
    localparam int unsigned WIDTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    shift_normalizer_if #(.WIDTH(WIDTH)) bus ();

    shift_normalizer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: count shifts until the first set bit reaches the chosen end.
    function automatic int ref_amt(input logic [7:0] v, input logic d);
        int          a = 0;
        logic [7:0]  w = v;
        if (w == 8'h00) return 0;
        while ((d ? !w[0] : !w[7]) && a < 7) begin
            w = d ? (w >> 1) : (w << 1);
            a++;
        end
        return a;
    endfunction

    // Behaviour of the companion shifter_8bit: dir 0 = left, 1 = right.
    function automatic logic [7:0] shifter_8bit(input logic [7:0] v, input int a, input logic d);
        return d ? (v >> a) : (v << a);
    endfunction

    // Drive a request now (caller sits mid-cycle) and confirm it was accepted.
    task automatic launch(input logic [7:0] d, input logic dr);
        bus.start   = 1'b1;
        bus.data_in = d;
        bus.dir     = dr;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("accept_busy", 32'(bus.busy), 32'd1);
    endtask

    // Wait (bounded) for done, then compare latency, busy window and result.
    task automatic await_result(input string tag, input int exp_lat, input logic [7:0] exp_out,
                                input int exp_amt, input logic exp_zero);
        int lat     = 0;
        bit busy_ok = 1'b1;
        for (int i = 0; i < int'(WIDTH) + 2; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) break;
            if (!bus.busy) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_window"}, 32'(busy_ok), 32'd1);
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        check({tag, "_data_out"}, 32'(bus.data_out), 32'(exp_out));
        check({tag, "_shift_amt"}, 32'(bus.shift_amt), 32'(exp_amt));
        check({tag, "_zero"}, 32'(bus.zero), 32'(exp_zero));
    endtask

    // One idle edge: done must have dropped, results must hold.
    task automatic idle_edge(input string tag, input logic [7:0] held_out);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_held"}, 32'(bus.data_out), 32'(held_out));
    endtask

    initial begin
        bit no_done;
        int a;

        // Reset asserted asynchronously with random inputs, before any clock edge.
        bus.start   = 1'($urandom);
        bus.data_in = 8'($urandom);
        bus.dir     = 1'($urandom);
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd0);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        check("rst_shift_amt", 32'(bus.shift_amt), 32'd0);
        repeat (2) @(posedge clk);
        bus.start = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Hand-computed vectors.
        launch(8'b0010_1010, 1'b0);
        await_result("v2a_left", 3, 8'b1010_1000, 2, 1'b0);
        idle_edge("v2a_left", 8'b1010_1000);

        launch(8'b1111_0000, 1'b1);
        await_result("vf0_right", 5, 8'b0000_1111, 4, 1'b0);
        idle_edge("vf0_right", 8'b0000_1111);

        launch(8'b1010_1010, 1'b0);
        await_result("vaa_left", 1, 8'b1010_1010, 0, 1'b0);
        idle_edge("vaa_left", 8'b1010_1010);

        launch(8'h00, 1'b0);
        await_result("zero_left", 1, 8'h00, 0, 1'b1);
        idle_edge("zero_left", 8'h00);

        launch(8'h00, 1'b1);
        await_result("zero_right", 1, 8'h00, 0, 1'b1);
        idle_edge("zero_right", 8'h00);

        // Worst case with a start pulse of 8'hFF injected while busy.
        launch(8'h01, 1'b0);
        @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.data_in = 8'hFF;
        bus.dir     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("ignored_start_busy", 32'(bus.busy), 32'd1);
        await_result("v01_left", 6, 8'h80, 7, 1'b0);
        idle_edge("v01_left", 8'h80);
        check("ignored_start_no_rerun", 32'(bus.busy), 32'd0);

        // Back-to-back: new request driven during the done cycle.
        launch(8'b0010_1010, 1'b0);
        await_result("b2b_first", 3, 8'b1010_1000, 2, 1'b0);
        launch(8'b0000_0110, 1'b1);
        check("b2b_done_drop", 32'(bus.done), 32'd0);
        await_result("b2b_second", 2, 8'b0000_0011, 1, 1'b0);
        idle_edge("b2b_second", 8'b0000_0011);

        // Round-trip sweep, every request accepted straight from the done cycle.
        for (int v = 1; v < 256; v++) begin
            for (int d = 0; d < 2; d++) begin
                a = ref_amt(8'(v), 1'(d));
                launch(8'(v), 1'(d));
                await_result("sweep", a + 1, shifter_8bit(8'(v), a, 1'(d)), a, 1'b0);
                check("round_trip", 32'(shifter_8bit(bus.data_out, int'(bus.shift_amt), ~1'(d))),
                      32'(v));
            end
        end
        idle_edge("sweep_end", bus.data_out);

        // Reset two cycles into a long operation aborts it with no done.
        launch(8'h01, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_data_out", 32'(bus.data_out), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        no_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) no_done = 1'b0;
        end
        check("abort_no_done", 32'(no_done), 32'd1);
        launch(8'b0010_1010, 1'b0);
        await_result("after_abort", 3, 8'b1010_1000, 2, 1'b0);
        idle_edge("after_abort", 8'b1010_1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
